// File: rtl/sync_fifo_v2_if.sv
// sync_fifo_v2_if: write, read, status and error signals of sync_fifo_v2.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface sync_fifo_v2_if #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8
);
    localparam int CWIDTH = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DWIDTH-1:0] din;
    logic              rd_en;
    logic [DWIDTH-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CWIDTH-1:0] count;
    logic              flush;
    logic              clr_err;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en, flush, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, flush, clr_err,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO for any DEPTH >= 2 with standard or
// first-word-fall-through read, occupancy count, programmable almost flags,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_v2 #(
    parameter int DWIDTH    = 16,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input logic            clk,
    input logic            rstn,
    sync_fifo_v2_if.slave  bus
);
    localparam int CWIDTH = $clog2(DEPTH + 1);
    localparam int AWIDTH = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              not_empty, not_full;
    logic              rd_ok, wr_ok;

    // Accept/reject decisions and next state; flush overrides everything and
    // suppresses both requests so they cannot raise error flags.
    always_comb begin
        not_empty = (count_q != '0);
        not_full  = (count_q != CWIDTH'(DEPTH));
        rd_ok     = bus.rd_en & ~bus.flush & not_empty;
        // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
        wr_ok     = bus.wr_en & ~bus.flush & (not_full | rd_ok);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths correct.
            if (wr_ok)
                wr_ptr_d = (wr_ptr_q == AWIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + AWIDTH'(1);
            if (rd_ok)
                rd_ptr_d = (rd_ptr_q == AWIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + AWIDTH'(1);
            count_d = count_q + CWIDTH'(wr_ok) - CWIDTH'(rd_ok);
        end

        // A new error in the same cycle as clr_err wins.
        ovf_d = ovf_q;
        if (bus.wr_en & ~bus.flush & ~wr_ok)
            ovf_d = 1'b1;
        else if (bus.clr_err)
            ovf_d = 1'b0;

        unf_d = unf_q;
        if (bus.rd_en & ~bus.flush & ~rd_ok)
            unf_d = 1'b1;
        else if (bus.clr_err)
            unf_d = 1'b0;
    end

    // Pointer, occupancy and sticky error registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; not reset, and no write lands while reset is held.
    always_ff @(posedge clk) begin
        if (rstn && wr_ok)
            mem_q[wr_ptr_q] <= bus.din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero while empty.
            always_comb bus.dout = not_empty ? mem_q[rd_ptr_q] : '0;
        end else begin : g_std
            logic [DWIDTH-1:0] dout_q;
            // Registered read: the popped word appears the cycle after rd_en.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    dout_q <= '0;
                else if (rd_ok)
                    dout_q <= mem_q[rd_ptr_q];
            end
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = ~not_full;
    assign bus.empty        = ~not_empty;
    assign bus.almost_full  = (count_q >= CWIDTH'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CWIDTH'(AE_THRESH));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
